dmem_responder: RTL and testbench

Multi-cycle data-memory responder that services load/store requests from the pipelined MIPS core over a valid/ready request channel and a valid/ready response channel. It replaces the single-cycle combinational data memory when the core is built with a stalling memory stage, and lets the team model realistic wait states. It holds one outstanding transaction, applies byte-enabled writes, and flags bad addresses with an error response.

---
 rtl/dmem_responder.sv | 114 +++++++++++
 tb/tb_dmem_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding load/store, byte-enabled writes,
// programmable wait states and an error response for misaligned or out-of-range addresses.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept_p0;
  logic          err_p0;
  logic [AW-1:0] idx_p0;

  // Upper address bits must be zero: addresses never alias back into the array.
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
  endfunction

  function automatic logic [31:0] merge_be(input logic [31:0] old_word,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

  assign req_ready = (state == IDLE);

  // accept stage (p0): decode request; reset blocks a same-edge accept
  assign accept_p0 = req_valid && req_ready && !reset;
  assign err_p0    = addr_bad(req_addr);
  assign idx_p0    = req_addr[AW+1:2];

  always_ff @(posedge clk) begin
    if (accept_p0 && req_we && !err_p0) begin
      mem[idx_p0] <= merge_be(mem[idx_p0], req_wdata, req_be);
    end
  end

  // response register stage: captured at accept, held until the handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_p0) begin
            resp_rdata <= (req_we || err_p0) ? 32'd0 : mem[idx_p0];
            resp_err   <= err_p0;
            if (LATENCY == 1) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              cnt        <= 4'd0;
            end else begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt <= 4'd1) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            cnt        <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          cnt        <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: LATENCY=2 instance for function/backpressure/reset,
// LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_ready, a_resp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
  logic [3:0]  a_req_be;
  logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_ready, b_resp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
  logic [3:0]  b_req_be;

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
  );

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int b_resp_cnt = 0;
  int b_last_hs = 0;
  logic [32:0] q_a[$];
  logic [32:0] q_b[$];
  logic [32:0] ea, eb;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: a response with resp_ready high at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (!reset && a_resp_valid && a_resp_ready) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_resp got err=%b rdata=%h expected no response", a_resp_err, a_resp_rdata);
      end else begin
        ea = q_a.pop_front();
        chk("a_resp {err,rdata}", {31'd0, a_resp_err, a_resp_rdata}, {31'd0, ea});
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && b_resp_valid && b_resp_ready) begin
      b_resp_cnt = b_resp_cnt + 1;
      b_last_hs  = cyc + 1;
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_resp got err=%b rdata=%h expected no response", b_resp_err, b_resp_rdata);
      end else begin
        eb = q_b.pop_front();
        chk("b_resp {err,rdata}", {31'd0, b_resp_err, b_resp_rdata}, {31'd0, eb});
      end
    end
  end

  // Waits for req_ready, presents one request for exactly one accept edge; returns at accept edge + #1.
  task automatic issue(input bit sel, input bit push, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input logic [32:0] exp);
    int n;
    bit rdy;
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 200) begin
      @(posedge clk); #1;
      n++;
      rdy = sel ? b_req_ready : a_req_ready;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout req_ready got 0 expected 1");
      return;
    end
    if (push) begin
      if (sel) q_b.push_back(exp);
      else     q_a.push_back(exp);
    end
    if (sel) begin
      b_req_we = we; b_req_addr = addr; b_req_wdata = wdata; b_req_be = be; b_req_valid = 1'b1;
    end else begin
      a_req_we = we; a_req_addr = addr; a_req_wdata = wdata; a_req_be = be; a_req_valid = 1'b1;
    end
    @(posedge clk); #1;
    if (sel) b_req_valid = 1'b0;
    else     a_req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (q_a.size() != 0 || q_b.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending got %0d expected 0", q_a.size() + q_b.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int base;
    int first_acc;
    bit seen;

    reset = 1'b1;
    a_req_valid = 0; a_req_we = 0; a_req_addr = 0; a_req_wdata = 0; a_req_be = 0; a_resp_ready = 1;
    b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_wdata = 0; b_req_be = 0; b_resp_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready",  {63'd0, a_req_ready}, 64'd1);
    chk("reset resp_valid", {63'd0, a_resp_valid}, 64'd0);
    chk("reset resp_rdata", {32'd0, a_resp_rdata}, 64'd0);
    chk("reset resp_err",   {63'd0, a_resp_err}, 64'd0);
    reset = 1'b0;

    // basic store with latency check, then load back
    issue(0, 1, 1, 32'h10, 32'hDEADBEEF, 4'hF, {1'b0, 32'd0});
    chk("lat store valid@k", {63'd0, a_resp_valid}, 64'd0);
    @(posedge clk); #1;
    chk("lat store valid@k+1", {63'd1 & 63'd0, a_resp_valid}, 64'd1);
    chk("lat store err",   {63'd0, a_resp_err}, 64'd0);
    chk("lat store rdata", {32'd0, a_resp_rdata}, 64'd0);
    issue(0, 1, 0, 32'h10, 32'd0, 4'h0, {1'b0, 32'hDEADBEEF});

    // byte enables
    issue(0, 1, 1, 32'h20, 32'hFFFFFFFF, 4'hF, {1'b0, 32'd0});
    issue(0, 1, 1, 32'h20, 32'h12345678, 4'b0101, {1'b0, 32'd0});
    issue(0, 1, 0, 32'h20, 32'd0, 4'h0, {1'b0, 32'hFF34FF78});
    issue(0, 1, 1, 32'h24, 32'hAABBCCDD, 4'h0, {1'b0, 32'd0});
    issue(0, 1, 0, 32'h24, 32'd0, 4'h0, {1'b0, 32'd0});

    // errors and last-word boundary
    issue(0, 1, 0, 32'h13, 32'd0, 4'h0, {1'b1, 32'd0});
    issue(0, 1, 0, 32'h100, 32'd0, 4'h0, {1'b1, 32'd0});
    issue(0, 1, 1, 32'h0, 32'h0BADF00D, 4'hF, {1'b0, 32'd0});
    issue(0, 1, 1, 32'h100, 32'hFFFFFFFF, 4'hF, {1'b1, 32'd0});
    issue(0, 1, 1, 32'h2, 32'hFFFFFFFF, 4'hF, {1'b1, 32'd0});
    issue(0, 1, 0, 32'h0, 32'd0, 4'h0, {1'b0, 32'h0BADF00D});
    issue(0, 1, 1, 32'hFC, 32'hCAFEF00D, 4'hF, {1'b0, 32'd0});
    issue(0, 1, 0, 32'hFC, 32'd0, 4'h0, {1'b0, 32'hCAFEF00D});
    issue(0, 1, 0, 32'h8000_0010, 32'd0, 4'h0, {1'b1, 32'd0});
    wait_drain();

    // backpressure with an ignored request pulse
    a_resp_ready = 1'b0;
    issue(0, 1, 0, 32'h10, 32'd0, 4'h0, {1'b0, 32'hDEADBEEF});
    n = 0;
    while (!a_resp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp resp_valid rose", {63'd0, a_resp_valid}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      a_req_valid = (i == 2); a_req_we = 1'b0; a_req_addr = 32'h20;
      @(posedge clk); #1;
      a_req_valid = 1'b0;
      chk("bp rdata held", {32'd0, a_resp_rdata}, {32'd0, 32'hDEADBEEF});
      chk("bp err held", {63'd0, a_resp_err}, 64'd0);
      chk("bp req_ready low", {63'd0, a_req_ready}, 64'd0);
      chk("bp valid held", {63'd0, a_resp_valid}, 64'd1);
    end
    a_resp_ready = 1'b1;
    wait_drain();
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (a_resp_valid) seen = 1'b1;
    end
    chk("bp pulse not accepted", {63'd0, seen}, 64'd0);

    // reset in WAIT drops the response but keeps the committed store
    issue(0, 0, 1, 32'h30, 32'hA5A5A5A5, 4'hF, 33'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst req_ready", {63'd0, a_req_ready}, 64'd1);
    seen = a_resp_valid;
    repeat (4) begin
      @(posedge clk); #1;
      if (a_resp_valid) seen = 1'b1;
    end
    chk("rst resp_valid never", {63'd0, seen}, 64'd0);
    issue(0, 1, 0, 32'h30, 32'd0, 4'h0, {1'b0, 32'hA5A5A5A5});
    wait_drain();

    // LATENCY=1 throughput: 8 back-to-back loads
    for (int i = 0; i < 8; i++) begin
      issue(1, 1, 1, 32'(i * 4), 32'h1000_0000 + 32'(i * 32'h0101), 4'hF, {1'b0, 32'd0});
    end
    wait_drain();
    base = b_resp_cnt;
    first_acc = 0;
    for (int i = 0; i < 8; i++) begin
      issue(1, 1, 0, 32'(i * 4), 32'd0, 4'h0, {1'b0, 32'h1000_0000 + 32'(i * 32'h0101)});
      if (i == 0) first_acc = cyc;
    end
    wait_drain();
    chk("tp response count", 64'(b_resp_cnt - base), 64'd8);
    chk("tp cycle span", 64'(b_last_hs - first_acc + 1), 64'd16);

    chk("final queue a empty", 64'(q_a.size()), 64'd0);
    chk("final queue b empty", 64'(q_b.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
